stack_frame_arb: RTL and testbench
==================================

STACK_FRAME_ARB -- requirements
Module: stack_frame_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, giving the stack word and entry-count width.
REQ-002 SHALL have parameter DEPTH, default 3468, giving the stack memory entries.
REQ-003 SHALL derive AW = clogb2(DEPTH-1), which is 12 at default; AW is not overridable.
REQ-004 SHALL have port: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have push ports:
- push_open  in  1  pulse; opens a frame at push_base.
- push_base  in  AW  frame base address (header location).
- push_valid  in  1  data beat valid.
- push_data  in  DATA_WIDTH  beat data.
- push_last  in  1  marks final beat of frame.
- push_ready  out  1  beat accepted when push_valid & push_ready.
REQ-007 SHALL have pop ports:
- pop_start  in  1  pulse; streams the frame at pop_base.
- pop_base  in  AW  frame base to read.
- pop_valid  out  1  pop_data valid.
- pop_data  out  DATA_WIDTH  streamed entry.
- pop_done  out  1  pulse, end of frame.
- pop_empty  out  1  pulse, frame header was 0.
REQ-008 SHALL have status ports:
- busy  out  1  either engine not idle.
- err_ovf  out  1  sticky push count overflow.
- err_overlap  out  1  pulse, rejected request.
REQ-009 SHALL have memory ports:
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write access.
- mem_addr  out  AW  single shared port address.
- mem_din  out  DATA_WIDTH  write data.
- mem_dout  in  DATA_WIDTH  read data, valid 1 cycle after a read access.

Function
REQ-010 SHALL lay out each frame as a header at base holding the entry count N, with entries at base+1..base+N; all address arithmetic is modulo 2^AW.
REQ-011 SHALL run the push engine through states P_IDLE -> P_OPEN -> P_HDR -> P_IDLE:
- push_open in P_IDLE latches the base, clears the count, clears err_ovf, and enters P_OPEN.
- push_open outside P_IDLE is ignored and pulses err_overlap.
REQ-012 SHALL request the port in P_OPEN when push_valid=1, and drive push_ready = P_OPEN & grant_push.
REQ-013 SHALL handle each accepted beat as follows:
- Write push_data to base+1+count, then count++.
- At count = 2^DATA_WIDTH-1 the beat is not written, count holds, and err_ovf is set.
REQ-014 SHALL, on an accepted beat with push_last=1, enter P_HDR after that beat's write.
REQ-015 SHALL, in P_HDR, request one write of the final count to base; when granted, return to P_IDLE.
REQ-016 SHALL run the pop engine through states Q_IDLE -> Q_HDR -> Q_LEN -> Q_RD -> Q_IDLE:
- pop_start in Q_IDLE latches the base and enters Q_HDR.
- pop_start outside Q_IDLE is ignored.
REQ-017 SHALL, in Q_HDR, request a read of base, then move to Q_LEN on the cycle after the grant and capture mem_dout as the remaining count.
REQ-018 SHALL, in Q_LEN with header 0, pulse pop_empty and pop_done in the same cycle and return to Q_IDLE; no data reads are issued.
REQ-019 SHALL, in Q_RD, request reads of base+1..base+N back-to-back, one per grant.
REQ-020 SHALL assert pop_valid with pop_data=mem_dout in the cycle after each granted data read, and assert pop_done together with the Nth pop_valid.
REQ-021 SHALL reject pop_start when the push engine is not in P_IDLE and pop_base equals the latched push base: err_overlap pulses and the pop engine stays idle.
REQ-022 SHALL arbitrate as follows:
- A single requester is granted immediately.
- On a conflict, the grant goes to the engine not granted at the previous conflict (round robin).
- The first conflict after reset grants push.
REQ-023 SHALL drive memory signals combinationally from the grant:
- mem_en = grant_push | grant_pop.
- mem_we = grant_push.
- mem_addr and mem_din come from the granted engine.
- When there is no grant, mem_addr and mem_din are 0.
REQ-024 SHALL allow push and pop engines to run concurrently on different frames.
REQ-025 SHALL drive busy = (push state != P_IDLE) | (pop state != Q_IDLE).

Reset
REQ-026 SHALL, on rst=1 at a clock edge:
- Place both engines in idle and set the RR pointer to push.
- Clear counts.
- Drive all outputs to 0 (push_ready, pop_valid, pop_done, pop_empty, busy, err_ovf, err_overlap, mem_en, mem_we, mem_addr, mem_din) from the next cycle.
REQ-027 SHALL, when rst is asserted mid-operation, abandon the operation: no header write follows and no pop_valid or pop_done is emitted afterwards.

Verification
REQ-028 Push frame at base 100 with beats 5,6,7 (last on 7), no pop traffic -> memory writes [101]=5, [102]=6, [103]=7, then [100]=3; push_ready high for 3 consecutive cycles; busy drops the cycle after the header write.
REQ-029 Pop at base 100 holding that frame -> header read, then 3 reads; pop_valid carries 5,6,7 on consecutive cycles; pop_done coincides with 7.
REQ-030 Pop at base 200 with [200]=0 -> pop_empty=pop_done=1 in the same cycle; exactly one mem_en cycle.
REQ-031 Push at base 300 and pop at base 100 both continuously requesting -> grants alternate push/pop starting with push; both frames complete with correct data.
REQ-032 Pop at base 300 while the push frame at base 300 is open -> err_overlap pulse, no pop_valid; push_open while a frame is open -> err_overlap pulse, push base unchanged.
REQ-033 rst asserted mid-pop after 1 of 3 data beats -> no further pop_valid or pop_done; all outputs 0 the next cycle; a new pop afterwards works normally.

Source files
------------

// File: rtl/stack_frame_arb_if.sv
// Push/pop/status/memory bundle for stack_frame_arb.
// The slave modport is the arbiter's view; master is the client/memory side.
interface stack_frame_arb_if #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned DEPTH      = 3468
);
  localparam int unsigned AW = $clog2(DEPTH - 1);

  logic                  push_open;
  logic [AW-1:0]         push_base;
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_last;
  logic                  push_ready;

  logic                  pop_start;
  logic [AW-1:0]         pop_base;
  logic                  pop_valid;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_done;
  logic                  pop_empty;

  logic                  busy;
  logic                  err_ovf;
  logic                  err_overlap;

  logic                  mem_en;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  push_open, push_base, push_valid, push_data, push_last,
    input  pop_start, pop_base, mem_dout,
    output push_ready, pop_valid, pop_data, pop_done, pop_empty,
    output busy, err_ovf, err_overlap,
    output mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output push_open, push_base, push_valid, push_data, push_last,
    output pop_start, pop_base, mem_dout,
    input  push_ready, pop_valid, pop_data, pop_done, pop_empty,
    input  busy, err_ovf, err_overlap,
    input  mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/stack_frame_arb.sv
// Frame stack engine: a push writer and a pop streamer sharing one single-port memory
// through a round-robin arbiter. Frame = header (count N) at base, entries at base+1..base+N.
module stack_frame_arb #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned DEPTH      = 3468
) (
  input logic               clk,
  input logic               rst,
  stack_frame_arb_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {PIdle, POpen, PHdr} push_st_e;
  typedef enum logic [1:0] {QIdle, QHdr, QLen, QRd} pop_st_e;

  push_st_e              push_st_q, push_st_d;
  logic [AW-1:0]         push_base_q, push_base_d;
  logic [DATA_WIDTH-1:0] push_cnt_q, push_cnt_d;
  logic                  err_ovf_q, err_ovf_d;

  pop_st_e               pop_st_q, pop_st_d;
  logic [AW-1:0]         pop_base_q, pop_base_d;
  logic [DATA_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
  logic [DATA_WIDTH-1:0] pop_idx_q, pop_idx_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  pop_last_q, pop_last_d;

  logic                  err_overlap_q, err_overlap_d;
  logic                  rr_pop_q, rr_pop_d;  // set: pop wins the next conflict

  logic                  req_push, req_pop, grant_push, grant_pop;
  logic                  push_beat, ovf_beat, push_wr, pop_empty_c;
  logic [AW-1:0]         push_addr, pop_addr;
  logic [DATA_WIDTH-1:0] push_wdata;

  // Arbiter
  assign req_push = ((push_st_q == POpen) && bus.push_valid) || (push_st_q == PHdr);
  assign req_pop  = (pop_st_q == QHdr) || (pop_st_q == QRd);

  always_comb begin
    grant_push = req_push && (!req_pop || !rr_pop_q);
    grant_pop  = req_pop && (!req_push || rr_pop_q);
    rr_pop_d   = rr_pop_q;
    if (req_push && req_pop) rr_pop_d = grant_push;
  end

  assign push_beat  = grant_push && (push_st_q == POpen);
  // A beat arriving at a saturated count is consumed but never reaches memory.
  assign ovf_beat   = push_beat && (push_cnt_q == CntMax);
  assign push_wr    = grant_push && !ovf_beat;
  assign push_addr  = (push_st_q == PHdr) ? push_base_q
                                          : push_base_q + AW'(push_cnt_q) + AW'(1);
  assign push_wdata = (push_st_q == PHdr) ? push_cnt_q : bus.push_data;
  assign pop_addr   = (pop_st_q == QHdr) ? pop_base_q
                                         : pop_base_q + AW'(pop_idx_q) + AW'(1);

  // Push engine
  always_comb begin
    push_st_d   = push_st_q;
    push_base_d = push_base_q;
    push_cnt_d  = push_cnt_q;
    err_ovf_d   = err_ovf_q;
    case (push_st_q)
      PIdle: begin
        if (bus.push_open) begin
          push_base_d = bus.push_base;
          push_cnt_d  = '0;
          err_ovf_d   = 1'b0;
          push_st_d   = POpen;
        end
      end
      POpen: begin
        if (push_beat) begin
          if (ovf_beat) err_ovf_d  = 1'b1;
          else          push_cnt_d = push_cnt_q + DATA_WIDTH'(1);
          if (bus.push_last) push_st_d = PHdr;
        end
      end
      PHdr: begin
        if (grant_push) push_st_d = PIdle;
      end
      default: push_st_d = PIdle;
    endcase
  end

  // Pop engine; the header read returns on mem_dout while in QLen.
  always_comb begin
    pop_st_d    = pop_st_q;
    pop_base_d  = pop_base_q;
    pop_cnt_d   = pop_cnt_q;
    pop_idx_d   = pop_idx_q;
    pop_valid_d = 1'b0;
    pop_last_d  = 1'b0;
    pop_empty_c = 1'b0;
    err_overlap_d = bus.push_open && (push_st_q != PIdle);
    unique case (pop_st_q)
      QIdle: begin
        if (bus.pop_start) begin
          if ((push_st_q != PIdle) && (bus.pop_base == push_base_q)) begin
            err_overlap_d = 1'b1;
          end else begin
            pop_base_d = bus.pop_base;
            pop_st_d   = QHdr;
          end
        end
      end
      QHdr: begin
        if (grant_pop) pop_st_d = QLen;
      end
      QLen: begin
        if (bus.mem_dout == '0) begin
          pop_empty_c = 1'b1;
          pop_st_d    = QIdle;
        end else begin
          pop_cnt_d = bus.mem_dout;
          pop_idx_d = '0;
          pop_st_d  = QRd;
        end
      end
      QRd: begin
        if (grant_pop) begin
          pop_valid_d = 1'b1;
          pop_idx_d   = pop_idx_q + DATA_WIDTH'(1);
          if (pop_idx_q == pop_cnt_q - DATA_WIDTH'(1)) begin
            pop_last_d = 1'b1;
            pop_st_d   = QIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push_st_q     <= PIdle;
      push_base_q   <= '0;
      push_cnt_q    <= '0;
      err_ovf_q     <= 1'b0;
      pop_st_q      <= QIdle;
      pop_base_q    <= '0;
      pop_cnt_q     <= '0;
      pop_idx_q     <= '0;
      pop_valid_q   <= 1'b0;
      pop_last_q    <= 1'b0;
      err_overlap_q <= 1'b0;
      rr_pop_q      <= 1'b0;
    end else begin
      push_st_q     <= push_st_d;
      push_base_q   <= push_base_d;
      push_cnt_q    <= push_cnt_d;
      err_ovf_q     <= err_ovf_d;
      pop_st_q      <= pop_st_d;
      pop_base_q    <= pop_base_d;
      pop_cnt_q     <= pop_cnt_d;
      pop_idx_q     <= pop_idx_d;
      pop_valid_q   <= pop_valid_d;
      pop_last_q    <= pop_last_d;
      err_overlap_q <= err_overlap_d;
      rr_pop_q      <= rr_pop_d;
    end
  end

  assign bus.push_ready  = push_beat;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.pop_data    = pop_valid_q ? bus.mem_dout : '0;
  assign bus.pop_empty   = pop_empty_c;
  assign bus.pop_done    = pop_last_q || pop_empty_c;
  assign bus.busy        = (push_st_q != PIdle) || (pop_st_q != QIdle);
  assign bus.err_ovf     = err_ovf_q;
  assign bus.err_overlap = err_overlap_q;
  assign bus.mem_en      = push_wr || grant_pop;
  assign bus.mem_we      = push_wr;
  assign bus.mem_addr    = push_wr ? push_addr : (grant_pop ? pop_addr : '0);
  assign bus.mem_din     = push_wr ? push_wdata : '0;
endmodule

// File: tb/tb_stack_frame_arb.sv
// Directed bench for stack_frame_arb: per-cycle vector table for push/overlap behaviour,
// plus hand sequences for pop streaming, arbitration, reset abort and count overflow.
module tb_stack_frame_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_frame_arb_if #(.DATA_WIDTH(10), .DEPTH(3468)) bus ();

  stack_frame_arb #(.DATA_WIDTH(10), .DEPTH(3468)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port memory model, one cycle read latency.
  logic [9:0] mem [4096];
  bit         mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      bus.mem_dout <= '0;
      mem_init <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
      else            bus.mem_dout <= mem[bus.mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " flags"}, 32'({bus.push_ready, bus.pop_valid, bus.pop_done, bus.pop_empty,
        bus.busy, bus.err_ovf, bus.err_overlap, bus.mem_en, bus.mem_we}), 0);
    chk({tag, " mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, " mem_din"}, 32'(bus.mem_din), 0);
  endtask

  task automatic idle_inputs();
    bus.push_open = 0; bus.push_base = '0; bus.push_valid = 0; bus.push_data = '0;
    bus.push_last = 0; bus.pop_start = 0; bus.pop_base = '0;
  endtask

  // Pops the frame at base and checks streamed data, timing and memory traffic.
  task automatic run_pop(input string tag, input int base, input int n,
                         input int d0, input int d1, input int d2);
    int d[3] = '{d0, d1, d2};
    int got[4];
    int beats = 0, ens = 0, first = -1, last = -1, done_at = -1, empty_at = -1;
    @(posedge clk); #1;
    bus.pop_start = 1; bus.pop_base = base[11:0];
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.mem_en) ens++;
      if (bus.pop_valid) begin
        if (beats < 4) got[beats] = int'(bus.pop_data);
        if (first < 0) first = c;
        last = c;
        beats++;
      end
      if (bus.pop_done) done_at = c;
      if (bus.pop_empty) empty_at = c;
      @(posedge clk); #1;
      bus.pop_start = 0;
    end
    chk({tag, " beats"}, beats, n);
    chk({tag, " mem_en cycles"}, ens, n + 1);
    if (n > 0) begin
      for (int i = 0; i < n; i++) chk({tag, " data"}, got[i], d[i]);
      chk({tag, " consecutive"}, last - first, n - 1);
      chk({tag, " done with last"}, done_at, last);
    end else begin
      chk({tag, " empty seen"}, 32'(empty_at >= 0), 1);
      chk({tag, " empty with done"}, done_at, empty_at);
    end
    chk({tag, " busy after"}, 32'(bus.busy), 0);
  endtask

  typedef struct {
    int po, pb, pv, pd, pl, ps, qb;       // stimulus
    int rdy, en, we, addr, din, bsy, ovl, pval;  // expected
  } vec_t;
  vec_t vecs[13];

  int acc_we[16], acc_addr[16], acc_din[16];
  int exp_we[8]   = '{1, 0, 1, 1, 0, 1, 0, 0};
  int exp_addr[8] = '{301, 100, 302, 303, 101, 300, 102, 103};
  int exp_din[8]  = '{11, 0, 12, 13, 0, 3, 0, 0};
  int beats3[3]   = '{11, 12, 13};
  int pop_got[4];

  initial begin
    int nacc, npop, ndone, pi, stray, missed;
    bit seen;

    vecs[0]  = '{1, 100, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0};
    vecs[1]  = '{0, 0,   1, 5, 0, 0, 0,   1, 1, 1, 101, 5, 1, 0, 0};
    vecs[2]  = '{0, 0,   1, 6, 0, 0, 0,   1, 1, 1, 102, 6, 1, 0, 0};
    vecs[3]  = '{0, 0,   1, 7, 1, 0, 0,   1, 1, 1, 103, 7, 1, 0, 0};
    vecs[4]  = '{0, 0,   0, 0, 0, 0, 0,   0, 1, 1, 100, 3, 1, 0, 0};
    vecs[5]  = '{0, 0,   0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0};
    vecs[6]  = '{1, 300, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0};
    vecs[7]  = '{1, 400, 0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 1, 0, 0};
    vecs[8]  = '{0, 0,   0, 0, 0, 1, 300, 0, 0, 0, 0,   0, 1, 1, 0};
    vecs[9]  = '{0, 0,   0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 1, 1, 0};
    vecs[10] = '{0, 0,   1, 9, 1, 0, 0,   1, 1, 1, 301, 9, 1, 0, 0};
    vecs[11] = '{0, 0,   0, 0, 0, 0, 0,   0, 1, 1, 300, 1, 1, 0, 0};
    vecs[12] = '{0, 0,   0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0};

    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 0;

    // Push frame at 100, then an overlapping push_open/pop_start against the open frame at 300.
    for (int i = 0; i < 13; i++) begin
      bus.push_open = vecs[i].po[0]; bus.push_base = vecs[i].pb[11:0];
      bus.push_valid = vecs[i].pv[0]; bus.push_data = vecs[i].pd[9:0];
      bus.push_last = vecs[i].pl[0]; bus.pop_start = vecs[i].ps[0];
      bus.pop_base = vecs[i].qb[11:0];
      @(negedge clk);
      chk($sformatf("v%0d push_ready", i), 32'(bus.push_ready), vecs[i].rdy);
      chk($sformatf("v%0d mem_en", i), 32'(bus.mem_en), vecs[i].en);
      chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), vecs[i].we);
      chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), vecs[i].addr);
      chk($sformatf("v%0d mem_din", i), 32'(bus.mem_din), vecs[i].din);
      chk($sformatf("v%0d busy", i), 32'(bus.busy), vecs[i].bsy);
      chk($sformatf("v%0d err_overlap", i), 32'(bus.err_overlap), vecs[i].ovl);
      chk($sformatf("v%0d pop_valid", i), 32'(bus.pop_valid), vecs[i].pval);
      @(posedge clk); #1;
    end
    idle_inputs();

    run_pop("pop100", 100, 3, 5, 6, 7);
    run_pop("pop200", 200, 0, 0, 0, 0);

    // Concurrent push@300 / pop@100 from a fresh arbiter.
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    nacc = 0; npop = 0; ndone = 0; pi = 0;
    bus.push_open = 1; bus.push_base = 12'd300; bus.pop_start = 1; bus.pop_base = 12'd100;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin bus.push_open = 0; bus.pop_start = 0; end
      bus.push_valid = (pi < 3);
      bus.push_data  = (pi < 3) ? beats3[pi][9:0] : 10'd0;
      bus.push_last  = (pi == 2);
      @(negedge clk);
      if (bus.mem_en && nacc < 16) begin
        acc_we[nacc] = int'(bus.mem_we); acc_addr[nacc] = int'(bus.mem_addr);
        acc_din[nacc] = int'(bus.mem_din); nacc++;
      end
      if (bus.pop_valid && npop < 4) begin pop_got[npop] = int'(bus.pop_data); npop++; end
      if (bus.pop_done) ndone++;
      if (bus.push_ready) pi++;
      @(posedge clk); #1;
    end
    idle_inputs();
    chk("rr access count", nacc, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr acc%0d we", i), acc_we[i], exp_we[i]);
      chk($sformatf("rr acc%0d addr", i), acc_addr[i], exp_addr[i]);
      if (exp_we[i] == 1) chk($sformatf("rr acc%0d din", i), acc_din[i], exp_din[i]);
    end
    chk("rr pop beats", npop, 3);
    for (int i = 0; i < 3; i++) chk("rr pop data", pop_got[i], 5 + i);
    chk("rr pop_done count", ndone, 1);
    run_pop("pop300", 300, 3, 11, 12, 13);

    // Reset after the first of three data beats.
    bus.pop_start = 1; bus.pop_base = 12'd100;
    @(posedge clk); #1;
    bus.pop_start = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.pop_valid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    chk("abort first beat seen", 32'(seen), 1);
    chk("abort first beat data", 32'(bus.pop_data), 5);
    rst = 1;
    @(negedge clk);
    chk_zero("abort reset");
    @(posedge clk); #1;
    rst = 0;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.pop_valid || bus.pop_done) stray++;
    end
    chk("abort stray outputs", stray, 0);
    run_pop("pop after abort", 100, 3, 5, 6, 7);

    // Count saturation: 1024 beats into a frame whose count tops out at 1023.
    @(posedge clk); #1;
    bus.push_open = 1; bus.push_base = 12'd2000;
    @(posedge clk); #1;
    bus.push_open = 0;
    missed = 0;
    for (int i = 0; i < 1024; i++) begin
      bus.push_valid = 1; bus.push_data = i[9:0]; bus.push_last = (i == 1023);
      @(negedge clk);
      if (!bus.push_ready) missed++;
      if (i == 1022) chk("ovf not yet set", 32'(bus.err_ovf), 0);
      if (i == 1023) chk("ovf beat not written", 32'(bus.mem_en), 0);
      @(posedge clk); #1;
    end
    idle_inputs();
    chk("ovf beats accepted", missed, 0);
    for (int c = 0; c < 20 && bus.busy; c++) begin @(posedge clk); #1; end
    chk("ovf push done", 32'(bus.busy), 0);
    chk("ovf sticky", 32'(bus.err_ovf), 1);
    chk("ovf header", 32'(mem[2000]), 1023);
    chk("ovf last entry", 32'(mem[3023]), 1022);
    chk("ovf dropped beat", 32'(mem[3024]), 0);
    bus.push_open = 1; bus.push_base = 12'd2500;
    @(posedge clk); #1;
    bus.push_open = 0;
    @(negedge clk);
    chk("ovf cleared by open", 32'(bus.err_ovf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
